voice_fetch: RTL and testbench

- Playback-side client of the RAM arbiter. Holds up to NUM_VOICES one-shot sample voices, each with its own start and end address.
- On every audio sample tick, issues one tagged read request per active voice to the arbiter, using the voice index as the request ID.
- Collects the tagged replies, mixes them with saturation and presents one 16-bit mixed sample to the audio output stage.
- Voice configuration comes from the sample-control logic; triggers come from the pad/UI logic.

---
 rtl/voice_fetch.sv | 266 ++++++++++++++++++++++++++
 tb/tb_voice_fetch.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_fetch.sv
`default_nettype none
// ============================================================================
// Module      : voice_fetch
// Description : Playback-side RAM arbiter client. Holds NUM_VOICES one-shot
//               sample voices, each with its own start/end word address. On
//               every sample_tick it issues one tagged read per active voice,
//               spacing the requests REQ_GAP cycles apart. It collects the
//               tagged replies, mixes them with saturation and presents one
//               16-bit sample per frame.
// Ports       : clk/reset            - clock, synchronous active-high reset
//               sample_tick          - audio-rate frame strobe
//               trigger              - per-voice start pulses
//               cfg_*                - voice start/end address writes
//               playback_addr/r_id_in/playback_req - tagged read request out
//               data_ready/from_ram/r_id_out       - tagged reply in
//               audio_out/audio_valid              - mixed sample out
//               active               - per-voice playing flags
//               overrun/underrun     - dropped tick / reply timeout pulses
// Revision    : 1.0 - initial release
// ============================================================================
module voice_fetch #(
    parameter int NUM_VOICES = 4,
    parameter int ID_W       = 3,
    parameter int ADDR_W     = 27,
    parameter int REQ_GAP    = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic [NUM_VOICES-1:0] trigger,
    input  logic                  cfg_we,
    input  logic [ID_W-1:0]       cfg_voice,
    input  logic [ADDR_W-1:0]     cfg_start,
    input  logic [ADDR_W-1:0]     cfg_end,
    output logic [ADDR_W-1:0]     playback_addr,
    output logic [ID_W-1:0]       r_id_in,
    output logic                  playback_req,
    input  logic                  data_ready,
    input  logic [15:0]           from_ram,
    input  logic [ID_W-1:0]       r_id_out,
    output logic [15:0]           audio_out,
    output logic                  audio_valid,
    output logic [NUM_VOICES-1:0] active,
    output logic                  overrun,
    output logic                  underrun
);

    // Accumulator wide enough to sum NUM_VOICES full-scale samples.
    localparam int ACC_W = 16 + $clog2(NUM_VOICES);
    localparam int GAP_W = $clog2(REQ_GAP) + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1) + 1;

    localparam logic signed [ACC_W-1:0] C_SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] C_SAT_MIN = ACC_W'(-32'sd32768);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_GAP   = 3'd2,
        S_WAIT  = 3'd3,
        S_MIX   = 3'd4
    } state_t;

    state_t                   state_q;
    logic [NUM_VOICES-1:0]    pending_q;
    logic [NUM_VOICES-1:0]    outstanding_q;
    logic [NUM_VOICES-1:0]    outstanding_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic [GAP_W-1:0]         gap_q;
    logic [TMR_W-1:0]         timer_q;
    logic [ADDR_W-1:0]        playback_addr_q;
    logic [ID_W-1:0]          r_id_in_q;
    logic                     playback_req_q;
    logic [15:0]              audio_out_q;
    logic                     audio_valid_q;
    logic                     overrun_q;
    logic                     underrun_q;

    logic [ADDR_W-1:0]        w_ptr [NUM_VOICES];
    logic [NUM_VOICES-1:0]    w_active;
    logic [NUM_VOICES-1:0]    w_sel_onehot;
    logic [ID_W-1:0]          w_sel_idx;
    logic [ADDR_W-1:0]        w_sel_ptr;
    logic [NUM_VOICES-1:0]    w_issue_en;
    logic [NUM_VOICES-1:0]    w_reply_hit;
    logic                     w_reply_any;
    logic signed [ACC_W-1:0]  w_reply_ext;
    logic [15:0]              w_sat;

    // Lowest pending voice wins; scanning downward leaves the lowest set bit.
    always_comb begin
        w_sel_onehot = '0;
        w_sel_idx    = '0;
        w_sel_ptr    = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (pending_q[v]) begin
                w_sel_onehot    = '0;
                w_sel_onehot[v] = 1'b1;
                w_sel_idx       = ID_W'(v);
            end
        end
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_sel_onehot[v]) begin
                w_sel_ptr = w_ptr[v];
            end
        end
    end

    // Only replies whose tag is still outstanding are accepted; tags beyond
    // NUM_VOICES never match any voice.
    always_comb begin
        w_reply_hit = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (data_ready && outstanding_q[v] && (r_id_out == ID_W'(v))) begin
                w_reply_hit[v] = 1'b1;
            end
        end
    end

    assign w_reply_any   = |w_reply_hit;
    assign w_reply_ext   = {{(ACC_W-16){from_ram[15]}}, from_ram};
    assign w_issue_en    = (state_q == S_ISSUE) ? w_sel_onehot : '0;
    assign outstanding_d = (outstanding_q & ~w_reply_hit) | w_issue_en;

    always_comb begin
        if (acc_q > C_SAT_MAX) begin
            w_sat = 16'h7FFF;
        end else if (acc_q < C_SAT_MIN) begin
            w_sat = 16'h8000;
        end else begin
            w_sat = acc_q[15:0];
        end
    end

    // Per-voice configuration, pointer and playing flag.
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        logic [ADDR_W-1:0] start_q;
        logic [ADDR_W-1:0] end_q;
        logic [ADDR_W-1:0] ptr_q;
        logic              active_q;
        logic              w_cfg_hit;
        logic [ADDR_W-1:0] w_ptr_inc;

        assign w_cfg_hit = cfg_we && (cfg_voice == ID_W'(v));
        assign w_ptr_inc = ptr_q + ADDR_W'(1);

        always_ff @(posedge clk) begin
            if (reset) begin
                start_q  <= '0;
                end_q    <= '0;
                ptr_q    <= '0;
                active_q <= 1'b0;
            end else begin
                if (w_cfg_hit) begin
                    start_q <= cfg_start;
                    end_q   <= cfg_end;
                end
                // A trigger overrides a same-cycle fetch of this voice: the
                // fetch already used the old pointer, the restart wins after.
                if (trigger[v] && (start_q != end_q)) begin
                    ptr_q    <= start_q;
                    active_q <= 1'b1;
                end else if (w_issue_en[v]) begin
                    ptr_q <= w_ptr_inc;
                    if (w_ptr_inc == end_q) begin
                        active_q <= 1'b0;
                    end
                end
            end
        end

        assign w_ptr[v]    = ptr_q;
        assign w_active[v] = active_q;
    end

    // Frame sequencer with registered request/audio outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            pending_q       <= '0;
            outstanding_q   <= '0;
            acc_q           <= '0;
            gap_q           <= '0;
            timer_q         <= '0;
            playback_addr_q <= '0;
            r_id_in_q       <= '0;
            playback_req_q  <= 1'b0;
            audio_out_q     <= '0;
            audio_valid_q   <= 1'b0;
            overrun_q       <= 1'b0;
            underrun_q      <= 1'b0;
        end else begin
            playback_req_q <= 1'b0;
            audio_valid_q  <= 1'b0;
            underrun_q     <= 1'b0;
            overrun_q      <= sample_tick && (state_q != S_IDLE);
            outstanding_q  <= outstanding_d;

            // Nothing is outstanding in IDLE, so clearing on the tick never
            // drops a reply.
            if ((state_q == S_IDLE) && sample_tick) begin
                acc_q <= '0;
            end else if (w_reply_any) begin
                acc_q <= acc_q + w_reply_ext;
            end

            case (state_q)
                S_IDLE: begin
                    if (sample_tick) begin
                        pending_q <= w_active;
                        state_q   <= (w_active == '0) ? S_MIX : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    playback_req_q  <= 1'b1;
                    playback_addr_q <= w_sel_ptr;
                    r_id_in_q       <= w_sel_idx;
                    pending_q       <= pending_q & ~w_sel_onehot;
                    gap_q           <= '0;
                    timer_q         <= '0;
                    state_q         <= S_GAP;
                end
                S_GAP: begin
                    timer_q <= timer_q + TMR_W'(1);
                    if (gap_q == GAP_W'(REQ_GAP - 2)) begin
                        state_q <= (pending_q != '0) ? S_ISSUE : S_WAIT;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                S_WAIT: begin
                    if (outstanding_q == '0) begin
                        state_q <= S_MIX;
                    end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        // Abandon missing replies so late ones are ignored.
                        underrun_q    <= 1'b1;
                        outstanding_q <= '0;
                        state_q       <= S_MIX;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                S_MIX: begin
                    audio_out_q   <= w_sat;
                    audio_valid_q <= 1'b1;
                    state_q       <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign playback_addr = playback_addr_q;
    assign r_id_in       = r_id_in_q;
    assign playback_req  = playback_req_q;
    assign audio_out     = audio_out_q;
    assign audio_valid   = audio_valid_q;
    assign active        = w_active;
    assign overrun       = overrun_q;
    assign underrun      = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_voice_fetch
// Description : Scoreboard bench for voice_fetch. Directed stimulus pushes
//               expected requests and mixed samples into queues; monitors pop
//               and compare whenever the DUT strobes playback_req/audio_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_fetch;

    localparam int NV  = 4;
    localparam int IDW = 3;
    localparam int AW  = 27;
    localparam int GAP = 4;
    localparam int TMO = 1023;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
    } req_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sample_tick = 1'b0;
    logic [NV-1:0] trigger = '0;
    logic          cfg_we = 1'b0;
    logic [IDW-1:0] cfg_voice = '0;
    logic [AW-1:0] cfg_start = '0;
    logic [AW-1:0] cfg_end = '0;
    logic [AW-1:0] playback_addr;
    logic [IDW-1:0] r_id_in;
    logic          playback_req;
    logic          data_ready = 1'b0;
    logic [15:0]   from_ram = '0;
    logic [IDW-1:0] r_id_out = '0;
    logic [15:0]   audio_out;
    logic          audio_valid;
    logic [NV-1:0] active;
    logic          overrun;
    logic          underrun;

    voice_fetch #(
        .NUM_VOICES (NV),
        .ID_W       (IDW),
        .ADDR_W     (AW),
        .REQ_GAP    (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .trigger       (trigger),
        .cfg_we        (cfg_we),
        .cfg_voice     (cfg_voice),
        .cfg_start     (cfg_start),
        .cfg_end       (cfg_end),
        .playback_addr (playback_addr),
        .r_id_in       (r_id_in),
        .playback_req  (playback_req),
        .data_ready    (data_ready),
        .from_ram      (from_ram),
        .r_id_out      (r_id_out),
        .audio_out     (audio_out),
        .audio_valid   (audio_valid),
        .active        (active),
        .overrun       (overrun),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    req_t        exp_req[$];
    logic [15:0] exp_audio[$];
    int frames = 0, req_cnt = 0, ovr_cnt = 0, und_cnt = 0;
    int last_req_cyc = -100, last_valid_cyc = 0, und_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Request monitor
    always @(negedge clk) begin
        if (playback_req) begin
            req_t r;
            if (exp_req.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got id=%0d addr=0x%0h expected none", r_id_in, playback_addr);
            end else begin
                r = exp_req.pop_front();
                chk("req_id", 64'(r_id_in), 64'(r.id));
                chk("req_addr", 64'(playback_addr), 64'(r.addr));
            end
            chk("req_spacing_ok", 64'(cyc - last_req_cyc >= GAP), 64'd1);
            last_req_cyc = cyc;
            req_cnt++;
        end
    end

    // Audio monitor
    always @(negedge clk) begin
        if (audio_valid) begin
            if (exp_audio.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_audio: got 0x%h expected no frame", audio_out);
            end else begin
                chk("audio_out", 64'(audio_out), 64'(exp_audio.pop_front()));
            end
            frames++;
            last_valid_cyc = cyc;
        end
        if (overrun) ovr_cnt++;
        if (underrun) begin
            und_cnt++;
            und_cyc = cyc;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int v, input logic [AW-1:0] s, input logic [AW-1:0] e);
        cfg_we = 1'b1; cfg_voice = IDW'(v); cfg_start = s; cfg_end = e;
        idle(1);
        cfg_we = 1'b0;
    endtask

    task automatic trig(input logic [NV-1:0] m);
        trigger = m;
        idle(1);
        trigger = '0;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        idle(1);
        sample_tick = 1'b0;
    endtask

    task automatic reply(input int id, input logic [15:0] val);
        data_ready = 1'b1; r_id_out = IDW'(id); from_ram = val;
        idle(1);
        data_ready = 1'b0;
    endtask

    task automatic push_req(input int id, input logic [AW-1:0] a);
        req_t r;
        r.id = IDW'(id);
        r.addr = a;
        exp_req.push_back(r);
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames < target && n < 3000) begin idle(1); n++; end
        chk("frames_reached", 64'(frames), 64'(target));
    endtask

    task automatic wait_reqs(input int target);
        int n = 0;
        while (req_cnt < target && n < 200) begin idle(1); n++; end
        chk("reqs_reached", 64'(req_cnt), 64'(target));
    endtask

    task automatic wait_underrun(input int target);
        int n = 0;
        while (und_cnt < target && n < 2000) begin idle(1); n++; end
        chk("underrun_reached", 64'(und_cnt), 64'(target));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_req"}, 64'(playback_req), 64'd0);
        chk({tag, "_addr"}, 64'(playback_addr), 64'd0);
        chk({tag, "_id"}, 64'(r_id_in), 64'd0);
        chk({tag, "_audio"}, 64'(audio_out), 64'd0);
        chk({tag, "_valid"}, 64'(audio_valid), 64'd0);
        chk({tag, "_active"}, 64'(active), 64'd0);
        chk({tag, "_ovr_und"}, 64'({overrun, underrun}), 64'd0);
    endtask

    initial begin
        int t0, rc, o0;
        // Reset state
        idle(3);
        check_zero_outputs("reset");
        reset = 1'b0;
        idle(2);

        // Empty frame latency
        exp_audio.push_back(16'h0000);
        t0 = cyc;
        tick();
        wait_frames(1);
        chk("empty_latency", 64'(last_valid_cyc - t0), 64'd2);
        chk("empty_no_req", 64'(req_cnt), 64'd0);

        // Single voice one-shot
        cfg(1, 27'h10, 27'h12);
        trig(4'b0010);
        chk("active_v1", 64'(active), 64'b0010);
        push_req(1, 27'h10); exp_audio.push_back(16'h0123);
        tick(); wait_reqs(1); reply(1, 16'h0123); wait_frames(2);
        push_req(1, 27'h11); exp_audio.push_back(16'h0456);
        tick(); wait_reqs(2);
        chk("active_v1_done", 64'(active), 64'd0);
        reply(1, 16'h0456); wait_frames(3);
        exp_audio.push_back(16'h0000);
        tick(); wait_frames(4);
        chk("no_req_after_end", 64'(req_cnt), 64'd2);

        // Four voices, out-of-order replies, saturation
        cfg(0, 27'h100, 27'h104);
        cfg(2, 27'h200, 27'h204);
        cfg(3, 27'h300, 27'h304);
        trig(4'b1111);
        chk("active_all", 64'(active), 64'b1111);
        push_req(0, 27'h100); push_req(1, 27'h10); push_req(2, 27'h200); push_req(3, 27'h300);
        exp_audio.push_back(16'h7FFF);
        tick(); wait_reqs(6);
        reply(3, 16'h7000); reply(1, 16'h7000); reply(0, 16'h7000); reply(2, 16'h7000);
        wait_frames(5);
        push_req(0, 27'h101); push_req(1, 27'h11); push_req(2, 27'h201); push_req(3, 27'h301);
        exp_audio.push_back(16'h8000);
        tick(); wait_reqs(10);
        reply(3, 16'h9000); reply(1, 16'h9000); reply(0, 16'h9000); reply(2, 16'h9000);
        wait_frames(6);
        chk("active_1101", 64'(active), 64'b1101);
        // Signed mix with a duplicate reply that must be ignored
        push_req(0, 27'h102); push_req(2, 27'h202); push_req(3, 27'h302);
        exp_audio.push_back(16'h0010);
        tick(); wait_reqs(13);
        reply(0, 16'h1000); reply(0, 16'h1000); reply(2, 16'hF000); reply(3, 16'h0010);
        wait_frames(7);
        push_req(0, 27'h103); push_req(2, 27'h203); push_req(3, 27'h303);
        exp_audio.push_back(16'h0003);
        tick(); wait_reqs(16);
        reply(0, 16'h0001); reply(2, 16'h0001); reply(3, 16'h0001);
        wait_frames(8);
        chk("active_none", 64'(active), 64'd0);

        // Timeout and late reply
        trig(4'b0100);
        push_req(2, 27'h200); exp_audio.push_back(16'h0000);
        tick(); wait_reqs(17);
        rc = last_req_cyc;
        wait_underrun(1);
        chk("underrun_delay", 64'(und_cyc - rc), 64'(TMO));
        wait_frames(9);
        reply(2, 16'h4000);
        push_req(2, 27'h201); exp_audio.push_back(16'h0005);
        tick(); wait_reqs(18); reply(2, 16'h0005); wait_frames(10);

        // Overrun while busy
        o0 = ovr_cnt;
        push_req(2, 27'h202); exp_audio.push_back(16'h0007);
        tick(); wait_reqs(19);
        tick(); idle(1);
        chk("overrun_pulse", 64'(ovr_cnt), 64'(o0 + 1));
        reply(2, 16'h0007); wait_frames(11);
        idle(5);
        chk("frames_after_overrun", 64'(frames), 64'd11);

        // Retrigger restarts from start
        trig(4'b0001);
        push_req(0, 27'h100); push_req(2, 27'h203); exp_audio.push_back(16'h0002);
        tick(); wait_reqs(21); reply(0, 16'h0001); reply(2, 16'h0001); wait_frames(12);
        chk("active_v0_only", 64'(active), 64'b0001);
        trig(4'b0001);
        push_req(0, 27'h100); exp_audio.push_back(16'h0009);
        tick(); wait_reqs(22); reply(0, 16'h0009); wait_frames(13);

        // Tick and trigger together: snapshot excludes the new voice
        push_req(0, 27'h101); exp_audio.push_back(16'h0002);
        trigger = 4'b1000; sample_tick = 1'b1;
        idle(1);
        trigger = '0; sample_tick = 1'b0;
        wait_reqs(23); reply(0, 16'h0002); wait_frames(14);
        idle(3);
        chk("snapshot_req_cnt", 64'(req_cnt), 64'd23);
        chk("active_1001", 64'(active), 64'b1001);

        // Reset mid-frame
        push_req(0, 27'h102);
        tick(); wait_reqs(24);
        reset = 1'b1;
        idle(3);
        check_zero_outputs("midreset");
        reset = 1'b0;
        reply(0, 16'h1234);
        idle(3);
        chk("no_frame_after_reset", 64'(frames), 64'd14);
        exp_audio.push_back(16'h0000);
        tick(); wait_frames(15);
        idle(5);
        chk("no_req_after_reset", 64'(req_cnt), 64'd24);
        chk("underrun_total", 64'(und_cnt), 64'd1);
        chk("exp_req_drained", 64'(exp_req.size()), 64'd0);
        chk("exp_audio_drained", 64'(exp_audio.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
